// File: rtl/hazard_ctrl_if.sv
// Pipeline hazard controller bundle: decode/execute status in, pipeline register controls and counters out.
interface hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_uses_rs;
  logic              id_uses_rt;
  logic              ex_mem_read;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_br_taken;
  logic              ex_mc_op;
  logic              cnt_clr;

  logic              pc_load;
  logic              ifid_load;
  logic              ifid_clear;
  logic              idex_load;
  logic              idex_clear;
  logic              exmem_load;
  logic              exmem_clear;
  logic              mc_busy;
  logic              mc_done;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_read, ex_rd,
           ex_br_taken, ex_mc_op, cnt_clr,
    input  pc_load, ifid_load, ifid_clear, idex_load, idex_clear,
           exmem_load, exmem_clear, mc_busy, mc_done, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_read, ex_rd,
           ex_br_taken, ex_mc_op, cnt_clr,
    output pc_load, ifid_load, ifid_clear, idex_load, idex_clear,
           exmem_load, exmem_clear, mc_busy, mc_done, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Load-use / branch-flush / multi-cycle-EX stall controller driving pipeline register load/clear,
// with saturating stall and flush counters.
module hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int MC_LAT = 4,
  parameter int CNT_W  = 16
) (
  input logic         clock,
  input logic         reset,
  hazard_ctrl_if.slave bus
);
  localparam int MCW = $clog2(MC_LAT) + 1;
  localparam logic [MCW-1:0] MC_INIT = (MC_LAT > 1) ? MCW'(MC_LAT - 2) : '0;
  localparam bit MC_STALLS = (MC_LAT > 1);

  typedef enum logic {RUN, MC_BUSY} state_t;

  state_t           r_state, w_state_nxt;
  logic [MCW-1:0]   r_mc_cnt, w_mc_cnt_nxt;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
  logic             w_lu, w_stall_inc, w_flush_inc;
  logic             w_pc_load, w_ifid_load, w_ifid_clear, w_idex_load, w_idex_clear;
  logic             w_exmem_load, w_exmem_clear, w_mc_done;

  assign w_lu = bus.ex_mem_read && (bus.ex_rd != '0) &&
                ((bus.id_uses_rs && (bus.id_rs == bus.ex_rd)) ||
                 (bus.id_uses_rt && (bus.id_rt == bus.ex_rd)));

  always_comb begin
    w_pc_load     = 1'b1;
    w_ifid_load   = 1'b1;
    w_ifid_clear  = 1'b0;
    w_idex_load   = 1'b1;
    w_idex_clear  = 1'b0;
    w_exmem_load  = 1'b1;
    w_exmem_clear = 1'b0;
    w_mc_done     = 1'b0;
    w_stall_inc   = 1'b0;
    w_flush_inc   = 1'b0;
    w_state_nxt   = r_state;
    w_mc_cnt_nxt  = r_mc_cnt;

    if (reset) begin
      w_pc_load     = 1'b0;
      w_ifid_load   = 1'b0;
      w_idex_load   = 1'b0;
      w_exmem_load  = 1'b0;
      w_ifid_clear  = 1'b1;
      w_idex_clear  = 1'b1;
      w_exmem_clear = 1'b1;
    end else begin
      unique case (r_state)
        RUN: begin
          if (bus.ex_br_taken) begin
            w_ifid_clear = 1'b1;
            w_idex_clear = 1'b1;
            w_flush_inc  = 1'b1;
          end else if (bus.ex_mc_op && MC_STALLS) begin
            w_pc_load     = 1'b0;
            w_ifid_load   = 1'b0;
            w_idex_load   = 1'b0;
            w_exmem_clear = 1'b1;
            w_stall_inc   = 1'b1;
            w_state_nxt   = MC_BUSY;
            w_mc_cnt_nxt  = MC_INIT;
          end else if (w_lu) begin
            // one bubble suffices: the load moves on to MEM and forwards from there
            w_pc_load    = 1'b0;
            w_ifid_load  = 1'b0;
            w_idex_clear = 1'b1;
            w_stall_inc  = 1'b1;
          end
        end
        MC_BUSY: begin
          if (r_mc_cnt != '0) begin
            w_pc_load     = 1'b0;
            w_ifid_load   = 1'b0;
            w_idex_load   = 1'b0;
            w_exmem_clear = 1'b1;
            w_stall_inc   = 1'b1;
            w_mc_cnt_nxt  = r_mc_cnt - 1'b1;
          end else begin
            w_mc_done   = 1'b1;
            w_state_nxt = RUN;
          end
        end
        default: w_state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= RUN;
      r_mc_cnt    <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_mc_cnt <= w_mc_cnt_nxt;
      if (bus.cnt_clr) begin
        r_stall_cnt <= '0;
        r_flush_cnt <= '0;
      end else begin
        if (w_stall_inc && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
        if (w_flush_inc && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 1'b1;
      end
    end
  end

  assign bus.pc_load     = w_pc_load;
  assign bus.ifid_load   = w_ifid_load;
  assign bus.ifid_clear  = w_ifid_clear;
  assign bus.idex_load   = w_idex_load;
  assign bus.idex_clear  = w_idex_clear;
  assign bus.exmem_load  = w_exmem_load;
  assign bus.exmem_clear = w_exmem_clear;
  assign bus.mc_busy     = (r_state == MC_BUSY) && !reset;
  assign bus.mc_done     = w_mc_done;
  assign bus.stall_cnt   = r_stall_cnt;
  assign bus.flush_cnt   = r_flush_cnt;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench: three controllers (MC_LAT=4, MC_LAT=1, CNT_W=4) share one stimulus stream.
module tb_hazard_ctrl;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] id_rs = '0, id_rt = '0, ex_rd = '0;
  logic       id_uses_rs = 0, id_uses_rt = 0, ex_mem_read = 0;
  logic       ex_br_taken = 0, ex_mc_op = 0, cnt_clr = 0;
  int         n_cmp = 0, n_err = 0;

  always #5 clock = ~clock;

  hazard_ctrl_if #(.REG_AW(5), .CNT_W(16)) u0_if ();
  hazard_ctrl_if #(.REG_AW(5), .CNT_W(16)) u1_if ();
  hazard_ctrl_if #(.REG_AW(5), .CNT_W(4))  u2_if ();

  hazard_ctrl #(.REG_AW(5), .MC_LAT(4), .CNT_W(16)) u0 (.clock(clock), .reset(reset), .bus(u0_if.slave));
  hazard_ctrl #(.REG_AW(5), .MC_LAT(1), .CNT_W(16)) u1 (.clock(clock), .reset(reset), .bus(u1_if.slave));
  hazard_ctrl #(.REG_AW(5), .MC_LAT(4), .CNT_W(4))  u2 (.clock(clock), .reset(reset), .bus(u2_if.slave));

  assign {u0_if.id_rs, u0_if.id_rt, u0_if.ex_rd} = {id_rs, id_rt, ex_rd};
  assign {u1_if.id_rs, u1_if.id_rt, u1_if.ex_rd} = {id_rs, id_rt, ex_rd};
  assign {u2_if.id_rs, u2_if.id_rt, u2_if.ex_rd} = {id_rs, id_rt, ex_rd};
  assign {u0_if.id_uses_rs, u0_if.id_uses_rt, u0_if.ex_mem_read, u0_if.ex_br_taken, u0_if.ex_mc_op, u0_if.cnt_clr} =
         {id_uses_rs, id_uses_rt, ex_mem_read, ex_br_taken, ex_mc_op, cnt_clr};
  assign {u1_if.id_uses_rs, u1_if.id_uses_rt, u1_if.ex_mem_read, u1_if.ex_br_taken, u1_if.ex_mc_op, u1_if.cnt_clr} =
         {id_uses_rs, id_uses_rt, ex_mem_read, ex_br_taken, ex_mc_op, cnt_clr};
  assign {u2_if.id_uses_rs, u2_if.id_uses_rt, u2_if.ex_mem_read, u2_if.ex_br_taken, u2_if.ex_mc_op, u2_if.cnt_clr} =
         {id_uses_rs, id_uses_rt, ex_mem_read, ex_br_taken, ex_mc_op, cnt_clr};

  // {pc_load, ifid_load, ifid_clear, idex_load, idex_clear, exmem_load, exmem_clear}
  wire [6:0] ctl0 = {u0_if.pc_load, u0_if.ifid_load, u0_if.ifid_clear, u0_if.idex_load,
                     u0_if.idex_clear, u0_if.exmem_load, u0_if.exmem_clear};
  wire [6:0] ctl1 = {u1_if.pc_load, u1_if.ifid_load, u1_if.ifid_clear, u1_if.idex_load,
                     u1_if.idex_clear, u1_if.exmem_load, u1_if.exmem_clear};
  localparam logic [6:0] C_RUN = 7'b1101010, C_RST = 7'b0010101, C_LU = 7'b0001110;
  localparam logic [6:0] C_BR  = 7'b1111110, C_MC  = 7'b0000011;

  task automatic idle();
    {id_rs, id_rt, ex_rd} = '0;
    {id_uses_rs, id_uses_rt, ex_mem_read, ex_br_taken, ex_mc_op, cnt_clr} = '0;
  endtask

  task automatic set_lu();
    ex_mem_read = 1; ex_rd = 5'd5; id_rs = 5'd5; id_uses_rs = 1;
  endtask

  task automatic test_reset();
    reset = 1; ex_mc_op = 1;
    repeat (3) @(negedge clock);
    #1;
    n_cmp++; if (ctl0 !== C_RST) begin n_err++; $display("FAIL rst_ctl act=%b exp=%b", ctl0, C_RST); end
    n_cmp++; if ({u0_if.mc_busy, u0_if.mc_done} !== 2'b00) begin n_err++;
      $display("FAIL rst_mc act=%b exp=00", {u0_if.mc_busy, u0_if.mc_done}); end
    n_cmp++; if ({u0_if.stall_cnt, u0_if.flush_cnt} !== 32'd0) begin n_err++;
      $display("FAIL rst_cnt act=%0d/%0d exp=0/0", u0_if.stall_cnt, u0_if.flush_cnt); end
    @(negedge clock); reset = 0; idle(); #1;
    n_cmp++; if (ctl0 !== C_RUN) begin n_err++; $display("FAIL rst_release act=%b exp=%b", ctl0, C_RUN); end
  endtask

  task automatic test_load_use();
    @(negedge clock); set_lu(); #1;
    n_cmp++; if (ctl0 !== C_LU) begin n_err++; $display("FAIL lu_ctl act=%b exp=%b", ctl0, C_LU); end
    @(negedge clock); idle(); #1;
    n_cmp++; if (ctl0 !== C_RUN) begin n_err++; $display("FAIL lu_one_cycle act=%b exp=%b", ctl0, C_RUN); end
    n_cmp++; if (u0_if.stall_cnt !== 16'd1) begin n_err++; $display("FAIL lu_stall_cnt act=%0d exp=1", u0_if.stall_cnt); end
  endtask

  task automatic test_reg0_unused();
    @(negedge clock); ex_mem_read = 1; ex_rd = 0; id_rs = 0; id_uses_rs = 1; #1;
    n_cmp++; if (ctl0 !== C_RUN) begin n_err++; $display("FAIL reg0 act=%b exp=%b", ctl0, C_RUN); end
    @(negedge clock); idle(); ex_mem_read = 1; ex_rd = 5'd7; id_rt = 5'd7; id_uses_rt = 0; id_uses_rs = 1; #1;
    n_cmp++; if (ctl0 !== C_RUN) begin n_err++; $display("FAIL unused_rt act=%b exp=%b", ctl0, C_RUN); end
    @(negedge clock); id_uses_rt = 1; #1;
    n_cmp++; if (ctl0 !== C_LU) begin n_err++; $display("FAIL rt_hit act=%b exp=%b", ctl0, C_LU); end
    @(negedge clock); idle(); #1;
    n_cmp++; if (u0_if.stall_cnt !== 16'd2) begin n_err++; $display("FAIL reg0_stall_cnt act=%0d exp=2", u0_if.stall_cnt); end
  endtask

  task automatic test_branch_vs_lu();
    @(negedge clock); set_lu(); ex_br_taken = 1; #1;
    n_cmp++; if (ctl0 !== C_BR) begin n_err++; $display("FAIL br_ctl act=%b exp=%b", ctl0, C_BR); end
    @(negedge clock); idle(); #1;
    n_cmp++; if ({u0_if.flush_cnt, u0_if.stall_cnt} !== {16'd1, 16'd2}) begin n_err++;
      $display("FAIL br_cnt act=%0d/%0d exp=1/2", u0_if.flush_cnt, u0_if.stall_cnt); end
  endtask

  task automatic test_multicycle();
    @(negedge clock); cnt_clr = 1;
    @(negedge clock); cnt_clr = 0; ex_mc_op = 1; #1;
    n_cmp++; if ({u0_if.stall_cnt, u1_if.stall_cnt, u0_if.flush_cnt} !== 48'd0) begin n_err++;
      $display("FAIL clr_cnt act=%0d/%0d/%0d exp=0/0/0", u0_if.stall_cnt, u1_if.stall_cnt, u0_if.flush_cnt); end
    for (int c = 1; c <= 4; c++) begin
      if (c > 1) begin @(negedge clock); #1; end
      n_cmp++; if (ctl0 !== ((c < 4) ? C_MC : C_RUN)) begin n_err++;
        $display("FAIL mc4_ctl cyc=%0d act=%b exp=%b", c, ctl0, (c < 4) ? C_MC : C_RUN); end
      n_cmp++; if (u0_if.mc_done !== (c == 4)) begin n_err++;
        $display("FAIL mc4_done cyc=%0d act=%b exp=%b", c, u0_if.mc_done, c == 4); end
      if (c == 2 || c == 3) begin
        n_cmp++; if (u0_if.mc_busy !== 1'b1) begin n_err++; $display("FAIL mc4_busy cyc=%0d act=%b exp=1", c, u0_if.mc_busy); end
      end
      n_cmp++; if ({ctl1, u1_if.mc_busy} !== {C_RUN, 1'b0}) begin n_err++;
        $display("FAIL mc1_nostall cyc=%0d act=%b/%b exp=%b/0", c, ctl1, u1_if.mc_busy, C_RUN); end
    end
    @(negedge clock); idle(); #1;
    n_cmp++; if ({u0_if.mc_busy, u0_if.mc_done} !== 2'b00) begin n_err++;
      $display("FAIL mc4_back_run act=%b exp=00", {u0_if.mc_busy, u0_if.mc_done}); end
    n_cmp++; if (u0_if.stall_cnt !== 16'd3) begin n_err++; $display("FAIL mc4_stall_cnt act=%0d exp=3", u0_if.stall_cnt); end
    n_cmp++; if (u1_if.stall_cnt !== 16'd0) begin n_err++; $display("FAIL mc1_stall_cnt act=%0d exp=0", u1_if.stall_cnt); end
  endtask

  task automatic test_saturation();
    // u2 starts at 3 from the multi-cycle test; 20 more stalls must pin it at 15
    for (int i = 0; i < 20; i++) begin @(negedge clock); set_lu(); end
    @(negedge clock); idle(); #1;
    n_cmp++; if (u2_if.stall_cnt !== 4'd15) begin n_err++; $display("FAIL sat_stall act=%0d exp=15", u2_if.stall_cnt); end
    n_cmp++; if (u0_if.stall_cnt !== 16'd23) begin n_err++; $display("FAIL wide_stall act=%0d exp=23", u0_if.stall_cnt); end
    @(negedge clock); set_lu(); cnt_clr = 1;
    @(negedge clock); idle(); #1;
    n_cmp++; if ({u2_if.stall_cnt, u0_if.stall_cnt} !== 20'd0) begin n_err++;
      $display("FAIL clr_prio act=%0d/%0d exp=0/0", u2_if.stall_cnt, u0_if.stall_cnt); end
  endtask

  task automatic test_reset_mid_busy();
    @(negedge clock); ex_mc_op = 1;
    @(negedge clock); ex_mc_op = 0; #1;
    n_cmp++; if (u0_if.mc_busy !== 1'b1) begin n_err++; $display("FAIL busy_pre_rst act=%b exp=1", u0_if.mc_busy); end
    reset = 1; #1;
    n_cmp++; if ({ctl0, u0_if.mc_busy} !== {C_RST, 1'b0}) begin n_err++;
      $display("FAIL busy_rst act=%b/%b exp=%b/0", ctl0, u0_if.mc_busy, C_RST); end
    @(negedge clock); reset = 0; #1;
    n_cmp++; if ({ctl0, u0_if.mc_busy, u0_if.mc_done} !== {C_RUN, 2'b00}) begin n_err++;
      $display("FAIL busy_abandon act=%b/%b%b exp=%b/00", ctl0, u0_if.mc_busy, u0_if.mc_done, C_RUN); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_reg0_unused();
    test_branch_vs_lu();
    test_multicycle();
    test_saturation();
    test_reset_mid_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard and stall controller. Sits directly upstream of the pipeline registers and drives their load/clear controls for the PC, IF/ID, ID/EX and EX/MEM stages.
- Resolves three conditions: load-use data hazards, taken-branch flushes, and multi-cycle EX operations such as mul/div.
- Keeps saturating performance counters for stall cycles and flushes.

Parameters:
- REG_AW, 5, register address width.
- MC_LAT, 4, number of cycles a multi-cycle op occupies EX (must be >= 1).
- CNT_W, 16, width of the performance counters.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- id_rs  in  REG_AW  source register 1 of the instruction in ID.
- id_rt  in  REG_AW  source register 2 of the instruction in ID.
- id_uses_rs  in  1  the instruction in ID reads rs.
- id_uses_rt  in  1  the instruction in ID reads rt.
- ex_mem_read  in  1  the instruction in EX is a load.
- ex_rd  in  REG_AW  destination register of the instruction in EX.
- ex_br_taken  in  1  branch/jump resolved taken in EX.
- ex_mc_op  in  1  a multi-cycle op is in EX.
- cnt_clr  in  1  synchronous clear of the performance counters.
- pc_load  out  1  PC register load enable.
- ifid_load, ifid_clear  out  1 each  IF/ID register controls.
- idex_load, idex_clear  out  1 each  ID/EX register controls.
- exmem_load, exmem_clear  out  1 each  EX/MEM register controls.
- mc_busy  out  1  the FSM is in MC_BUSY.
- mc_done  out  1  one-cycle pulse on the cycle the multi-cycle result is released.
- stall_cnt  out  CNT_W  saturating count of stall cycles.
- flush_cnt  out  CNT_W  saturating count of branch flushes.

Behaviour:
- Control outputs are combinational (Mealy) functions of the FSM state and the inputs.
- Downstream registers give clear priority over load. When no hazard is present: all loads = 1, all clears = 0.
- State: a 1-bit FSM (RUN, MC_BUSY), a down-counter mc_cnt of width clog2(MC_LAT)+1, and the two counters.
- Reset (asynchronous): state = RUN, mc_cnt = 0, stall_cnt = 0, flush_cnt = 0.
- While reset is high: all *_load = 0, all *_clear = 1, mc_busy = 0, mc_done = 0.
- Load-use hit (lu) = ex_mem_read & (ex_rd != 0) & ((id_uses_rs & id_rs == ex_rd) | (id_uses_rt & id_rt == ex_rd)).
- RUN, priority order:
  1. ex_br_taken: pc_load = 1, ifid_clear = 1, idex_clear = 1, exmem_load = 1. An lu in the same cycle is ignored. flush_cnt += 1.
  2. ex_mc_op with MC_LAT > 1: pc_load = ifid_load = idex_load = 0, exmem_clear = 1. Next state = MC_BUSY, mc_cnt = MC_LAT-2. stall_cnt += 1.
  3. lu: pc_load = ifid_load = 0, idex_clear = 1 (bubble), exmem_load = 1. stall_cnt += 1. The stall is exactly one cycle because the load advances to MEM.
  4. Otherwise: normal advance.
- ex_mc_op with MC_LAT == 1: no stall, state remains RUN.
- MC_BUSY, mc_cnt != 0: same stall outputs as RUN case 2; mc_cnt -= 1; stall_cnt += 1.
- MC_BUSY, mc_cnt == 0 (release): all loads = 1, all clears = 0, mc_done = 1, next state = RUN.
- In MC_BUSY, ex_br_taken, lu and ex_mc_op are ignored (EX holds the multi-cycle op).
- Result: the multi-cycle op occupies EX for exactly MC_LAT cycles, with MC_LAT-1 stall cycles.
- Counters saturate at all-ones. cnt_clr has priority over increment.
- Reset asserted mid-MC_BUSY: the FSM returns to RUN immediately; the op is abandoned.

Test Plan:
- Reset: assert reset for 3 cycles, with ex_mc_op = 1 held during reset -> all clears = 1, all loads = 0, counters = 0. After release with all inputs 0 -> all loads = 1, all clears = 0.
- Load-use hazard: ex_mem_read = 1, ex_rd = 5, id_rs = 5, id_uses_rs = 1 for one cycle -> pc_load = 0, ifid_load = 0, idex_clear = 1 for that cycle only; stall_cnt = 1.
- Register 0 / unused operand:
  - ex_rd = 0, id_rs = 0 -> no stall.
  - ex_rd = 7, id_rt = 7, id_uses_rt = 0 -> no stall.
- Branch beats load-use: ex_br_taken = 1 together with an lu condition -> ifid_clear = idex_clear = 1, pc_load = 1; flush_cnt = 1, stall_cnt unchanged.
- Multi-cycle op, MC_LAT = 4: ex_mc_op = 1 -> 3 stall cycles with exmem_clear = 1 and mc_busy = 1 for cycles 2–3. Cycle 4: mc_done = 1 and all loads = 1. stall_cnt = 3. Repeat with MC_LAT = 1 -> zero stall cycles.
- Saturation and clear:
  - CNT_W = 4, 20 consecutive lu cycles -> stall_cnt holds at 15.
  - cnt_clr together with an lu cycle -> stall_cnt = 0.
